// File: rtl/univ_rotate_seq_reg_if.sv
// Command/data bus of the universal rotate/shift sequencer register.
// The master drives commands and the slave returns register state and status.
interface univ_rotate_seq_reg_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] data;
    logic          sin;
    logic [DW-1:0] q;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, op, amt, cnt, data, sin,
        input  cmd_ready, q, busy, done
    );

    modport slave (
        input  cmd_valid, op, amt, cnt, data, sin,
        output cmd_ready, q, busy, done
    );
endinterface

// File: rtl/univ_rotate_seq_reg.sv
// Universal rotate/shift register with a repeat sequencer (IDLE/RUN).
// Optional UNIV_ROT_ABORT_EN adds an abort input that ends a RUN early.
module univ_rotate_seq_reg #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 4
) (
    input  logic clk,
    input  logic async_rst_n,
`ifdef UNIV_ROT_ABORT_EN
    input  logic abort,
`endif
    univ_rotate_seq_reg_if.slave bus
);
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ROTL = 3'b010;
    localparam logic [2:0] OP_ROTR = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SAR  = 3'b110;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic          done_q, done_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] amt_q, amt_d;
    logic          sin_q, sin_d;
    logic [CW-1:0] rem_q, rem_d;

    // One step of any operation applied to the current value x.
    function automatic logic [DW-1:0] step_f(input logic [2:0] o, input logic [AW-1:0] a,
                                             input logic s, input logic [DW-1:0] d,
                                             input logic [DW-1:0] x);
        logic [2*DW-1:0] dbl;
        logic [DW-1:0]   ones;
        logic [DW-1:0]   res;
        int unsigned     r;
        r    = 32'(a) % DW;
        ones = '1;
        dbl  = {x, x};
        res  = x;
        case (o)
            OP_HOLD: res = x;
            OP_LOAD: res = d;
            OP_ROTL: begin dbl = dbl << r; res = dbl[2*DW-1 -: DW]; end
            OP_ROTR: begin dbl = dbl >> r; res = dbl[DW-1:0]; end
            OP_SHL:  res = (x << a) | (s ? ~(ones << a) : '0);
            OP_SHR:  res = (x >> a) | (s ? ~(ones >> a) : '0);
            OP_SAR:  res = (x >> a) | (x[DW-1] ? ~(ones >> a) : '0);
            default: res = '0;
        endcase
        return res;
    endfunction

    logic multi_op;
    assign multi_op = (bus.op >= OP_ROTL) && (bus.op <= OP_SAR);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
            op_q    <= OP_HOLD;
            amt_q   <= '0;
            sin_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            sin_q   <= sin_d;
            rem_q   <= rem_d;
        end
    end

    // First step lands on the accepting edge; RUN covers the remaining cnt steps.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = 1'b0;
        op_d    = op_q;
        amt_d   = amt_q;
        sin_d   = sin_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    q_d = step_f(bus.op, bus.amt, bus.sin, bus.data, q_q);
                    if (multi_op && (bus.cnt != '0)) begin
                        op_d    = bus.op;
                        amt_d   = bus.amt;
                        sin_d   = bus.sin;
                        rem_d   = bus.cnt;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
`ifdef UNIV_ROT_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else
`endif
                begin
                    q_d   = step_f(op_q, amt_q, sin_q, '0, q_q);
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.q         = q_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.cmd_ready = (state_q != RUN);
endmodule

// File: tb/tb_univ_rotate_seq_reg.sv
// Randomised + directed bench for univ_rotate_seq_reg against a step-count model.
module tb_univ_rotate_seq_reg;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    logic abort;
    int   n_checks = 0;
    int   n_fail   = 0;

    univ_rotate_seq_reg_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    univ_rotate_seq_reg #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .async_rst_n(rst_n),
`ifdef UNIV_ROT_ABORT_EN
        .abort      (abort),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: value, number of steps still owed, and the parameters of the pending command.
    logic [DW-1:0] mq = '0;
    logic          mdone = 1'b0;
    int            left = 0;
    logic [2:0]    lop = '0;
    int            lamt = 0;
    logic          lsin = 1'b0;

    function automatic logic [DW-1:0] apply(input logic [2:0] o, input int a, input logic s,
                                            input logic [DW-1:0] d, input logic [DW-1:0] x);
        logic [DW-1:0] y;
        logic          fill;
        y = x;
        case (o)
            3'd0: y = x;
            3'd1: y = d;
            3'd2: for (int k = 0; k < a % int'(DW); k++) y = {y[DW-2:0], y[DW-1]};
            3'd3: for (int k = 0; k < a % int'(DW); k++) y = {y[0], y[DW-1:1]};
            3'd4: for (int k = 0; k < a; k++) y = {y[DW-2:0], s};
            3'd5: for (int k = 0; k < a; k++) y = {s, y[DW-1:1]};
            3'd6: begin fill = x[DW-1]; for (int k = 0; k < a; k++) y = {fill, y[DW-1:1]}; end
            default: y = '0;
        endcase
        return y;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq = '0; mdone = 1'b0; left = 0;
        end else begin
            mdone = 1'b0;
            if (left > 0) begin
                if (abort) begin
`ifdef UNIV_ROT_ABORT_EN
                    left = 0; mdone = 1'b1;
`else
                    mq = apply(lop, lamt, lsin, '0, mq); left--; if (left == 0) mdone = 1'b1;
`endif
                end else begin
                    mq = apply(lop, lamt, lsin, '0, mq); left--;
                    if (left == 0) mdone = 1'b1;
                end
            end else if (bus.cmd_valid) begin
                mq = apply(bus.op, int'(bus.amt), bus.sin, bus.data, mq);
                if (bus.op >= 3'd2 && bus.op <= 3'd6 && bus.cnt != 0) begin
                    left = int'(bus.cnt); lop = bus.op; lamt = int'(bus.amt); lsin = bus.sin;
                end else mdone = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison on every falling edge.
    always @(negedge clk) begin
        chk("q", bus.q, mq);
        chk("busy", DW'(bus.busy), DW'(left > 0));
        chk("cmd_ready", DW'(bus.cmd_ready), DW'(left == 0));
        chk("done", DW'(bus.done), DW'(mdone));
    end

    // Pin both DUT and model to a hand-computed value.
    task automatic lit(input string name, input logic [DW-1:0] exp);
        chk({name, " dut"}, bus.q, exp);
        chk({name, " model"}, mq, exp);
    endtask

    task automatic send(input logic [2:0] o, input int a, input int c,
                        input logic [DW-1:0] d, input logic s);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.op = o; bus.amt = AW'(a); bus.cnt = CW'(c);
        bus.data = d; bus.sin = s;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (bus.busy) begin n_fail++; $display("FAIL wait_idle: busy still 1 expected 0"); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.op = '0; bus.amt = '0; bus.cnt = '0;
        bus.data = '0; bus.sin = 1'b0; abort = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        lit("reset q", 8'h00);

        send(3'd1, 0, 0, 8'hA5, 0);  lit("load A5", 8'hA5);
        chk("load done", DW'(bus.done), 8'h01);
        send(3'd2, 3, 0, 8'h00, 0);  lit("rotl3", 8'h2D);
        send(3'd3, 1, 3, 8'h00, 0);  lit("rotr s1", 8'h96);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.op = 3'd1; bus.data = 8'hFF; bus.cnt = '0;
        @(posedge clk); #1 lit("rotr s2", 8'h4B);
        @(posedge clk); #1 lit("rotr s3", 8'hA5);
        @(posedge clk); #1 lit("rotr s4", 8'hD2);
        bus.cmd_valid = 1'b0;
        chk("rotr done", DW'(bus.done), 8'h01);

        send(3'd6, 2, 1, 8'h00, 0);  lit("sar s1", 8'hF4);
        @(posedge clk); #1 lit("sar s2", 8'hFD);
        send(3'd7, 0, 0, 8'h00, 0);  lit("clr", 8'h00);
        send(3'd4, 7, 0, 8'h00, 1);  lit("shl7 fill1", 8'h7F);
        send(3'd5, 7, 0, 8'h00, 0);  lit("shr7 fill0", 8'h00);

        send(3'd1, 0, 0, 8'h81, 0);
        send(3'd2, 1, 15, 8'h00, 0);
        repeat (4) begin @(posedge clk); #1; end
        lit("rotl 5 steps", 8'h30);
        #2 rst_n = 1'b0;
        #1 lit("mid-run reset", 8'h00);
        chk("reset busy", DW'(bus.busy), 8'h00);
        @(negedge clk); #1 rst_n = 1'b1;
        send(3'd1, 0, 0, 8'h3C, 0);  lit("load 3C", 8'h3C);

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.op = 3'd1; bus.data = 8'h11; bus.cnt = '0;
        @(posedge clk); #1 lit("b2b load", 8'h11);
        chk("b2b done1", DW'(bus.done), 8'h01);
        bus.op = 3'd2; bus.amt = 3'd4;
        @(posedge clk); #1 lit("b2b rotl4", 8'h11);
        chk("b2b done2", DW'(bus.done), 8'h01);
        bus.cmd_valid = 1'b0;

`ifdef UNIV_ROT_ABORT_EN
        send(3'd1, 0, 0, 8'h01, 0);
        send(3'd2, 1, 7, 8'h00, 0);
        repeat (2) begin @(posedge clk); #1; end
        lit("pre-abort", 8'h08);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        lit("abort hold", 8'h08);
        chk("abort busy", DW'(bus.busy), 8'h00);
        chk("abort done", DW'(bus.done), 8'h01);
`endif

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            bus.op   = 3'($urandom_range(0, 7));
            bus.amt  = AW'($urandom_range(0, (1 << AW) - 1));
            bus.cnt  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 2));
            bus.data = DW'($urandom);
            bus.sin  = 1'($urandom);
            abort    = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0; abort = 1'b0;
        wait_idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/univ_rotate_seq_reg.md
Name: univ_rotate_seq_reg

Overview:
Parametrised successor to the team's 4-bit universal rotate register. It adds barrel rotate/shift by a variable amount, logical and arithmetic shifts with a serial fill bit, and multi-step commands. A valid/ready command handshake and a small sequencer repeat one operation over consecutive cycles. It sits in datapath blocks that need scrambling, bit alignment or serial-parallel conversion.

Parameters:
DW, 8, data width (>=2)
AW, 3, amount width; amt range 0..2**AW-1
CW, 4, repeat-count width

Ports:
clk  in  1  clock, rising edge
async_rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted (= ~busy, combinational)
op  in  3  operation code
amt  in  AW  rotate/shift amount per step
cnt  in  CW  extra repeats; command runs cnt+1 steps
data  in  DW  load value
sin  in  1  serial fill bit for SHL/SHR
q  out  DW  register contents
busy  out  1  multi-step command in progress
done  out  1  one-cycle pulse after final step

Behaviour:
- Reset (async, while async_rst_n=0): q=0, busy=0, done=0, state IDLE, internal latches cleared. Reset mid-run aborts the command without a done pulse.
- Accept: cmd_valid & cmd_ready at a rising edge. Ignored while busy: no effect on q, no latch.
- op codes:
  - 000 HOLD: no change.
  - 001 LOAD: q<=data.
  - 010 ROTL by amt mod DW.
  - 011 ROTR by amt mod DW.
  - 100 SHL: shift left by amt, fill LSBs with sin.
  - 101 SHR: shift right by amt, fill MSBs with sin.
  - 110 SAR: shift right by amt, fill with q[DW-1] of the current step.
  - 111 CLR: q<=0.
- amt=0 leaves q unchanged but still counts as a step. For a shift with amt>=DW, q becomes all fill.
- HOLD, LOAD and CLR always run a single step; cnt is ignored.
- FSM IDLE/RUN:
  - The first step is applied on the accepting edge.
  - If op is a rotate/shift and cnt>0: latch op, amt, sin; rem<=cnt; go to RUN.
  - In RUN, each edge applies one step and decrements rem. The edge where rem==1 applies the last step and returns to IDLE.
  - Total latency is cnt+1 edges.
  - busy = (state==RUN).
- done: registered, high for exactly one cycle after the edge applying the final step of any accepted command, including single-step commands. A new command may be accepted in the done cycle (back-to-back), which gives consecutive done pulses.

Optional Feature:
UNIV_ROT_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 at an edge in RUN returns to IDLE without applying that step; q keeps its value and done pulses the next cycle. abort is ignored in IDLE.
- Undefined: no abort port; RUN always completes cnt+1 steps.

Test Plan:
1. Reset, then LOAD data=8'hA5 -> q=A5 after one edge; done one pulse; busy stays 0.
2. From A5, ROTL amt=3 cnt=0 -> q=2D; cmd_ready stays 1.
3. From 2D, ROTR amt=1 cnt=3 -> q=96,4B,A5,D2 on successive edges. busy=1 for 3 cycles with cmd_ready=0, and a LOAD 8'hFF offered then is ignored. done pulses after D2.
4. From D2, SAR amt=2 cnt=1 -> F4 then FD. Then CLR, then SHL amt=7 sin=1 -> 7F. Then SHR amt=7 sin=0 -> 00.
5. From 81, ROTL amt=1 cnt=15; drop async_rst_n between edges after 5 steps -> q=00, busy=0 immediately, no done. After release, LOAD 3C -> q=3C.
6. Hold cmd_valid with LOAD 11 then ROTL amt=4 cnt=0 on consecutive edges -> q=11, then 11; done high two consecutive cycles. With UNIV_ROT_ABORT_EN: ROTL amt=1 cnt=7 from 01, abort on the 3rd RUN edge -> q=08 held, done pulses once.
